// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester front end for one single-port synchronous RAM.
// Grants at most one access per cycle and registers the RAM pins from the winner.
// Read data returns two edges after the transfer edge, steered by a 2-deep tag pipe.
// Optional build macro ARB_FIXED_PRIO_EN: port 0 always wins contention and the
// round-robin pointer is removed. Default (undefined): round-robin.
module ram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    // port 0
    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    output logic          gnt0_o,
    output logic          rvalid0_o,
    // port 1
    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          gnt1_o,
    output logic          rvalid1_o,
    // shared read return
    output logic [DW-1:0] rdata_o,
    // RAM pins
    output logic          ram_wr_o,
    output logic          ram_rd_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_din_o,
    input  logic [DW-1:0] ram_dout_i
);

    // port 1 wins this cycle; everything else follows from this one bit
    logic pick1;

`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = req1_i & ~req0_i;
`else
    logic prio_q, prio_d;
    assign pick1 = req1_i & (~req0_i | prio_q);
`endif

    // grants are forced low while reset is held so no client sees a phantom transfer
    assign gnt0_o = rst_n_i & req0_i & ~pick1;
    assign gnt1_o = rst_n_i & pick1;

    logic          xfer;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    assign xfer      = gnt0_o | gnt1_o;
    assign win_we    = pick1 ? we1_i    : we0_i;
    assign win_addr  = pick1 ? addr1_i  : addr0_i;
    assign win_wdata = pick1 ? wdata1_i : wdata0_i;

    logic          ram_wr_q,   ram_wr_d;
    logic          ram_rd_q,   ram_rd_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q,  ram_din_d;
    // tag pipe: [0] set on the read transfer edge, [1] while the RAM produces data
    logic [1:0]    tag_vld_q,  tag_vld_d;
    logic [1:0]    tag_id_q,   tag_id_d;
    logic          rvalid0_q,  rvalid0_d;
    logic          rvalid1_q,  rvalid1_d;
    logic [DW-1:0] rdata_q,    rdata_d;

    // next-state: command registers load only on a transfer, strobes clear when idle
    always_comb begin
        ram_wr_d   = xfer & win_we;
        ram_rd_d   = xfer & ~win_we;
        ram_addr_d = xfer ? win_addr  : ram_addr_q;
        ram_din_d  = xfer ? win_wdata : ram_din_q;

        tag_vld_d  = {tag_vld_q[0], xfer & ~win_we};
        tag_id_d   = {tag_id_q[0],  pick1};

        rvalid0_d  = tag_vld_q[1] & ~tag_id_q[1];
        rvalid1_d  = tag_vld_q[1] &  tag_id_q[1];
        rdata_d    = tag_vld_q[1] ? ram_dout_i : rdata_q;
    end

`ifndef ARB_FIXED_PRIO_EN
    // round-robin: after a transfer the other port gets priority
    always_comb begin
        prio_d = prio_q;
        if (xfer) prio_d = gnt0_o;
    end

    // priority pointer register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) prio_q <= 1'b0;
        else          prio_q <= prio_d;
    end
`endif

    // RAM command, tag pipe and read-return registers; reset drops in-flight reads
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ram_wr_q   <= 1'b0;
            ram_rd_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ram_wr_q   <= ram_wr_d;
            ram_rd_q   <= ram_rd_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign ram_wr_o   = ram_wr_q;
    assign ram_rd_o   = ram_rd_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_din_o  = ram_din_q;
    assign rvalid0_o  = rvalid0_q;
    assign rvalid1_o  = rvalid1_q;
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural synchronous RAM behind it.
module tb_ram_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          ram_wr, ram_rd;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .gnt0_o(gnt0), .rvalid0_o(rvalid0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt1_o(gnt1), .rvalid1_o(rvalid1),
        .rdata_o(rdata),
        .ram_wr_o(ram_wr), .ram_rd_o(ram_rd), .ram_addr_o(ram_addr),
        .ram_din_o(ram_din), .ram_dout_i(ram_dout)
    );

    // single-port synchronous RAM, untouched by reset
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        if (ram_rd) ram_dout <= mem[ram_addr];
    end

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    // leaves the bench at posedge+1 with reset released
    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        req0 = 1; we0 = 1; addr0 = 8'h01; wdata0 = 8'h77;
        @(negedge clk);
        n_cmp++; if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL reset_gnt0 got %b want 0", gnt0); end
        n_cmp++; if ({ram_wr, ram_rd} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes got %b want 00", {ram_wr, ram_rd}); end
        n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid got %b want 00", {rvalid0, rvalid1}); end
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h want 00", rdata); end
        @(posedge clk); #1;
        n_cmp++; if (ram_wr !== 1'b0) begin n_bad++; $display("FAIL reset_hold_wr got %b want 0", ram_wr); end
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_single_port();
        apply_reset();
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
        @(negedge clk);
        n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++; $display("FAIL single_gnt got %b want 10", {gnt0, gnt1}); end
        @(posedge clk); #1;
        n_cmp++; if ({ram_wr, ram_rd, ram_addr, ram_din} !== {2'b10, 8'h10, 8'hA5})
            begin n_bad++; $display("FAIL single_wr_cmd got %b%b %h %h want 10 10 a5", ram_wr, ram_rd, ram_addr, ram_din); end
        we0 = 0;
        @(posedge clk); #1;
        req0 = 0;
        n_cmp++; if ({ram_wr, ram_rd} !== 2'b01) begin n_bad++; $display("FAIL single_rd_cmd got %b want 01", {ram_wr, ram_rd}); end
        @(posedge clk); #1;
        n_cmp++; if (rvalid0 !== 1'b0) begin n_bad++; $display("FAIL single_early_rvalid got %b want 0", rvalid0); end
        n_cmp++; if ({ram_wr, ram_rd, ram_addr} !== {2'b00, 8'h10})
            begin n_bad++; $display("FAIL single_idle_hold got %b%b %h want 00 10", ram_wr, ram_rd, ram_addr); end
        @(posedge clk); #1;
        n_cmp++; if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'hA5})
            begin n_bad++; $display("FAIL single_rd_data got %b%b %h want 10 a5", rvalid0, rvalid1, rdata); end
        @(posedge clk); #1;
        n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin n_bad++; $display("FAIL single_pulse got %b want 00", {rvalid0, rvalid1}); end
    endtask

    // port 0 writes addr 20, port 1 reads addr 21, both held for 4 cycles
    task automatic test_contention();
        logic e0;
        apply_reset();
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h11;
        req1 = 1; we1 = 0; addr1 = 8'h21;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            e0 = 1'b1;
`else
            e0 = (i % 2 == 0);
`endif
            @(negedge clk);
            n_cmp++; if ({gnt0, gnt1} !== {e0, ~e0})
                begin n_bad++; $display("FAIL contend_gnt[%0d] got %b want %b", i, {gnt0, gnt1}, {e0, ~e0}); end
            @(posedge clk); #1;
            n_cmp++; if ({ram_wr, ram_rd, ram_addr} !== {e0, ~e0, (e0 ? 8'h20 : 8'h21)})
                begin n_bad++; $display("FAIL contend_cmd[%0d] got %b%b %h want %b%b %h", i, ram_wr, ram_rd, ram_addr, e0, ~e0, (e0 ? 8'h20 : 8'h21)); end
        end
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_cross_raw();
        apply_reset();
        req0 = 1; we0 = 1; addr0 = 8'hFF; wdata0 = 8'h3C;
        @(posedge clk); #1;
        req0 = 0; req1 = 1; we1 = 0; addr1 = 8'hFF;
        @(negedge clk);
        n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_bad++; $display("FAIL raw_gnt got %b want 01", {gnt0, gnt1}); end
        @(posedge clk); #1;
        req1 = 0;
        @(posedge clk); #1;
        n_cmp++; if (rvalid1 !== 1'b0) begin n_bad++; $display("FAIL raw_early got %b want 0", rvalid1); end
        @(posedge clk); #1;
        n_cmp++; if ({rvalid0, rvalid1, rdata} !== {2'b01, 8'h3C})
            begin n_bad++; $display("FAIL raw_data got %b%b %h want 01 3c", rvalid0, rvalid1, rdata); end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        req1 = 1; we1 = 1; addr1 = 8'h33; wdata1 = 8'h5A;
        @(posedge clk); #1;
        req1 = 0; req0 = 1; we0 = 0; addr0 = 8'h33;
        @(posedge clk); #1;
        req0 = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #2;
        n_cmp++; if ({rvalid0, rvalid1, rdata} !== {2'b00, 8'h00})
            begin n_bad++; $display("FAIL midrd_in_reset got %b%b %h want 00 00", rvalid0, rvalid1, rdata); end
        #1 rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if ({rvalid0, rvalid1} !== 2'b00)
                begin n_bad++; $display("FAIL midrd_ghost[%0d] got %b want 00", i, {rvalid0, rvalid1}); end
        end
        req0 = 1; we0 = 0; addr0 = 8'h33;
        @(posedge clk); #1;
        req0 = 0;
        @(posedge clk);
        @(posedge clk); #1;
        n_cmp++; if ({rvalid0, rdata} !== {1'b1, 8'h5A})
            begin n_bad++; $display("FAIL midrd_reread got %b %h want 1 5a", rvalid0, rdata); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single_port();
        test_contention();
        test_cross_raw();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
